four_bit_serial_sub: RTL and testbench
======================================

FOUR_BIT_SERIAL_SUB -- requirements
Module: four_bit_serial_sub

Interface
REQ-001 Parameter: WIDTH, 4, operand and difference width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-004 Port: start  input  1  request; sampled on each rising clk edge.
REQ-005 Port: A  input  WIDTH  minuend; sampled only when start is accepted.
REQ-006 Port: B  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-007 Port: Bin  input  1  borrow-in; sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; D and Bout are valid.
REQ-010 Port: D  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
REQ-011 Port: Bout  output  1  borrow-out; 1 when A < B + Bin, unsigned.

Function
REQ-012 States: IDLE, SHIFT and DONE; a WIDTH-counter bit index runs in SHIFT.
REQ-013 IDLE or DONE with start=1 at edge k: latch A, B and Bin, clear the index, and enter SHIFT.
REQ-014 SHIFT: each edge processes one bit, LSB first, through one full-subtractor cell, shifts the difference bit into D and stores the borrow for the next bit.
REQ-015 After WIDTH SHIFT edges (edge k+WIDTH), enter DONE; done=1 for exactly the cycle following edge k+WIDTH.
REQ-016 DONE with start=0: return to IDLE at the next edge.
REQ-017 Latency: start sampled at edge k gives valid D and Bout in the cycle after edge k+WIDTH; minimum issue interval is WIDTH+1 cycles.
REQ-018 busy=1 exactly while the state is SHIFT.
REQ-019 done=1 exactly while the state is DONE.
REQ-020 start=1 while busy is ignored; the operation in flight and its operands are unaffected.
REQ-021 A, B and Bin changing while busy have no effect.
REQ-022 D and Bout hold the last completed result through IDLE until the next accepted start.
REQ-023 From the first SHIFT edge onward, D and Bout are don't-care until done.
REQ-024 Arithmetic is unsigned and modulo 2^WIDTH; Bout is the borrow out of the MSB cell.

Reset
REQ-025 Asserting rst_n low immediately forces: state IDLE, busy=0, done=0, D=0, Bout=0, index=0, and the operand/borrow registers=0.
REQ-026 A reset mid-operation aborts that operation; no done pulse is produced for it.
REQ-027 First start accepted: the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro: SERIAL_SUB_OVF_EN.
REQ-029 With the macro defined, add output port Ovf (1 bit): two's-complement overflow, meaning the sign of A differs from the sign of B and the sign of D differs from the sign of A.
REQ-030 Ovf follows the timing and reset rules of Bout.
REQ-031 Without the macro, the Ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package serial_sub_pkg holds: the state enum type (IDLE, SHIFT, DONE), WIDTH_DEFAULT=4, and the index-counter width constant.
REQ-033 Sub-module full_subtractor (ports A, B, Bin, D, Bout; combinational, one bit) is instantiated exactly once and reused every SHIFT cycle.

Verification
REQ-034 A=5, B=3, Bin=0, start pulse -> busy for 4 cycles, then done=1 with D=2, Bout=0.
REQ-035 A=3, B=5, Bin=0 -> D=14, Bout=1; with SERIAL_SUB_OVF_EN, Ovf=0.
REQ-036 A=0, B=0, Bin=1 -> D=15, Bout=1.
REQ-037 A=8, B=1, Bin=0 with SERIAL_SUB_OVF_EN -> D=7, Bout=0, Ovf=1.
REQ-038 Start A=9, B=4; two cycles later start again with A=1, B=2 while busy -> single done with D=5, Bout=0.
REQ-039 Start A=9, B=4, drop rst_n on the 2nd SHIFT cycle -> all outputs 0 and no done; after release, A=6, B=6 -> D=0, Bout=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 4;

  // Index counter width for a given operand width; never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int IDX_W = idx_width(WIDTH_DEFAULT);

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/four_bit_serial_sub.sv
// rtl/four_bit_serial_sub.sv - LSB-first bit-serial subtractor; optional Ovf output under SERIAL_SUB_OVF_EN
module four_bit_serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             Bout
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_d, cell_bout;

  full_subtractor u_cell (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .Bin  (borrow_q),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          state_d  = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // After WIDTH shifts the first (LSB) difference bit has reached bit 0.
        d_d      = {cell_d, d_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (cell_d ^ a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_serial_sub.sv
// tb/tb_four_bit_serial_sub.sv - randomized self-checking bench against an arithmetic reference model
module tb_four_bit_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout;
  logic [W-1:0] D;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  four_bit_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf   (Ovf),
`endif
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [W-1:0] exp_d;
  logic         exp_bout;
  logic         exp_ovf;

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int diff;
    diff     = int'(a) - int'(b) - int'(bin);
    exp_d    = diff[W-1:0];
    exp_bout = (diff < 0);
    exp_ovf  = (a[W-1] != b[W-1]) && (exp_d[W-1] != a[W-1]);
  endtask

  // Entered at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit mid_start);
    model(a, b, bin);
    start = 1'b1; A = a; B = b; Bin = bin;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      start = (mid_start && i == 1) ? 1'b1 : 1'b0;
      check("busy_shift", busy, 1);
      check("done_shift", done, 0);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("d_result", D, exp_d);
    check("bout_result", Bout, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf_result", Ovf, exp_ovf);
`endif
  endtask

  task automatic idle_check();
    start = 1'b0;
    @(negedge clk);
    check("done_idle", done, 0);
    check("busy_idle", busy, 0);
    check("d_hold", D, exp_d);
    check("bout_hold", Bout, exp_bout);
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", D, 0);
    check("rst_bout", Bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd5, 4'd3, 1'b0, 1'b0); idle_check();
    run_op(4'd3, 4'd5, 1'b0, 1'b0); idle_check();
    run_op(4'd0, 4'd0, 1'b1, 1'b0); idle_check();
    run_op(4'd8, 4'd1, 1'b0, 1'b0); idle_check();
    run_op(4'd9, 4'd4, 1'b0, 1'b1); idle_check();
    run_op(4'd15, 4'd15, 1'b1, 1'b0);
    run_op(4'd7, 4'd8, 1'b0, 1'b0); idle_check();

    // Abort mid-operation with an asynchronous reset.
    start = 1'b1; A = 4'd9; B = 4'd4; Bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", D, 0);
    check("abort_bout", Bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run_op(4'd6, 4'd6, 1'b0, 1'b0); idle_check();

    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
